// File: rtl/instr_ctrl_if.sv
// Control bus between instr_ctrl_fsm and the Project B datapath.
// The FSM side drives every control and only reads IR.
interface instr_ctrl_if;
    logic [15:0] IR;
    logic        PC_clr;
    logic        PC_up;
    logic        IR_ld;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  state_out;

    modport master (
        input  IR,
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, state_out
    );

    modport slave (
        output IR,
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, state_out
    );
endinterface

// File: rtl/instr_ctrl_fsm.sv
// Moore fetch/decode/execute sequencer for the Project B processor.
// Outputs depend only on the current state and the instruction register.
module instr_ctrl_fsm (
    input  logic              clk,
    input  logic              reset_n,
    instr_ctrl_if.master      bus
);
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_INIT;
        else          state_q <= state_d;
    end

    // Next state: IR only matters while in DECODE.
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.IR[15:12])
                    4'b0001: state_d = S_STORE;
                    4'b0010: state_d = S_LOAD_A;
                    4'b0011: state_d = S_ADD;
                    4'b0100: state_d = S_SUB;
                    4'b0101: state_d = S_HALT;
                    default: state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = 8'h00;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = 4'h0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = 4'h0;
        bus.RF_Rb_addr = 4'h0;
        bus.ALU_s0     = 3'b000;
        bus.state_out  = state_q;
        case (state_q)
            S_INIT: bus.PC_clr = 1'b1;
            S_FETCH: begin
                bus.IR_ld = 1'b1;
                bus.PC_up = 1'b1;
            end
            // Operands are presented early so memory and register reads settle.
            S_DECODE: begin
                bus.D_addr     = bus.IR[11:4];
                bus.RF_Ra_addr = bus.IR[11:8];
                bus.RF_Rb_addr = bus.IR[7:4];
            end
            S_LOAD_A: bus.D_addr = bus.IR[11:4];
            S_LOAD_B: begin
                bus.D_addr    = bus.IR[11:4];
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = bus.IR[3:0];
                bus.RF_W_en   = 1'b1;
            end
            S_STORE: begin
                bus.D_addr     = bus.IR[11:4];
                bus.RF_Ra_addr = bus.IR[3:0];
                bus.D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                bus.RF_Ra_addr = bus.IR[11:8];
                bus.RF_Rb_addr = bus.IR[7:4];
                bus.ALU_s0     = (state_q == S_SUB) ? 3'b010 : 3'b001;
                bus.RF_W_addr  = bus.IR[3:0];
                bus.RF_W_en    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/instr_ctrl_fsm.md
# instr_ctrl_fsm

Moore control state machine that sequences the Project B processor through fetch, decode and execute. It consumes the 16-bit instruction held by the instruction register. It drives the program-counter clear/increment, the instruction-register load, data-memory address/write, register-file addresses/write controls and the ALU select. It sits between the instruction register and the datapath and is the only source of datapath control.

## Interface
Parameters:
- none. Widths are fixed by the Project B instruction format.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- IR  in  16  current instruction from instruction register output
- PC_clr  out  1  clear program counter to 0
- PC_up  out  1  increment program counter
- IR_ld  out  1  load instruction register from instruction memory
- D_addr  out  8  data memory address
- D_wr  out  1  data memory write enable
- RF_s  out  1  register-file write-data select: 1 = data memory, 0 = ALU
- RF_W_addr  out  4  register-file write address
- RF_W_en  out  1  register-file write enable
- RF_Ra_addr  out  4  register-file read port A address
- RF_Rb_addr  out  4  register-file read port B address
- ALU_s0  out  3  ALU function: 000 pass A, 001 A+B, 010 A−B
- state_out  out  4  current state code, for debug and verification

## Operation
- Instruction format: opcode = IR[15:12].
  - NOOP 0000
  - STORE 0001: mem[IR[11:4]] ← R[IR[3:0]]
  - LOAD 0010: R[IR[3:0]] ← mem[IR[11:4]]
  - ADD 0011: R[IR[3:0]] ← R[IR[11:8]] + R[IR[7:4]]
  - SUB 0100: R[IR[3:0]] ← R[IR[11:8]] − R[IR[7:4]]
  - HALT 0101
  - Opcodes 0110–1111 execute as NOOP.
- State codes: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9. Codes 10–15 are unreachable and recover to INIT on the next edge.
- Transitions:
  - INIT→FETCH
  - FETCH→DECODE
  - DECODE→opcode state
  - LOAD_A→LOAD_B
  - NOOP, LOAD_B, STORE, ADD, SUB → FETCH
  - HALT→HALT; exit only by reset.
- Outputs are a pure function of the current state and IR. Every control defaults to 0 and every address defaults to 0 unless listed for that state:
  - INIT: PC_clr=1.
  - FETCH: IR_ld=1, PC_up=1.
  - DECODE: no strobes. D_addr=IR[11:4], RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4] (pre-presents operands).
  - LOAD_A: D_addr=IR[11:4]. Allows one cycle of memory read latency.
  - LOAD_B: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=1.
  - STORE: D_addr=IR[11:4], RF_Ra_addr=IR[3:0], ALU_s0=000, D_wr=1.
  - ADD: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], ALU_s0=001, RF_s=0, RF_W_addr=IR[3:0], RF_W_en=1.
  - SUB: same as ADD with ALU_s0=010.
  - HALT: all outputs 0.
- IR is sampled only in DECODE and execute states. IR changes during FETCH are expected; the new value takes effect at the FETCH→DECODE edge.
- At most one of D_wr and RF_W_en is high in any cycle. PC_clr and PC_up are never both high.

## Timing
- Reset: if reset_n=0 at a rising edge, state becomes INIT, independent of the current state, including mid-LOAD and HALT.
  - Outputs after reset: state_out=0, PC_clr=1, all other outputs 0.
  - While reset_n is held low, the FSM stays in INIT.
- First FETCH occurs on the first edge with reset_n=1. PC is therefore 0 during the first FETCH.
- Instruction latency, counted from the start of FETCH to the start of the next FETCH:
  - NOOP/STORE/ADD/SUB/undefined: 3 cycles.
  - LOAD: 4 cycles.
  - HALT: 2 cycles to reach HALT, then stays there.
- IR_ld and PC_up are high for exactly one cycle per instruction.
- Write strobes (D_wr, RF_W_en) are high for exactly one cycle per instruction.
- No combinational path from IR to state; the next state depends on IR only in DECODE.

## Test plan
- Reset: hold reset_n=0 for 2 edges, then release. Required: state_out=0 and PC_clr=1 during reset; state_out goes 1, then 2, on successive edges; IR_ld=1 and PC_up=1 only in state 1.
- ADD: IR=16'h3125. Required sequence FETCH→DECODE→ADD→FETCH. In ADD: RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=5, ALU_s0=001, RF_W_en=1, RF_s=0.
- SUB and STORE:
  - IR=16'h4ABC. Required: in SUB, ALU_s0=010, RF_W_addr=C.
  - IR=16'h11F3. Required: in STORE, D_addr=8'h1F, RF_Ra_addr=3, D_wr=1, RF_W_en=0.
- LOAD: IR=16'h2407. Required: LOAD_A with D_addr=8'h40 and all strobes 0. Then LOAD_B with D_addr=8'h40, RF_s=1, RF_W_addr=7, RF_W_en=1. Total 4 cycles from FETCH to FETCH.
- HALT and undefined opcode:
  - IR=16'hF000. Required: executes as NOOP (state 3), returns to FETCH.
  - IR=16'h5000. Required: enters state 9 and stays there ≥10 cycles with all outputs 0, even if IR changes.
- Reset mid-operation:
  - Assert reset_n=0 during LOAD_A. Required: next state INIT, RF_W_en never pulses.
  - Assert reset_n=0 during HALT. Required: returns to INIT, then FETCH after release.
